// File: rtl/ib_mul_qs_seq_if.sv
// Operand/product handshake bundle for ib_mul_qs_seq.
//   slave  : the multiplier side (takes operands, returns the product)
//   master : the requester side (drives operands, takes the product)
// Signals:
//   i_valid / o_ready : operand pair handshake, i_a and i_b are WIDTH-bit unsigned
//   o_valid / i_ready : product handshake, o_c is 2*WIDTH-bit unsigned
//   o_busy            : multiplier is not idle
interface ib_mul_qs_seq_if #(
    parameter int WIDTH = 8
);
    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_a;
    logic [WIDTH-1:0]   i_b;
    logic               o_valid;
    logic               i_ready;
    logic [2*WIDTH-1:0] o_c;
    logic               o_busy;

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_c, o_busy
    );

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_c, o_busy
    );
endinterface

// File: rtl/ib_mul_qs_seq.sv
// Sequential unsigned multiplier using quarter squares:
//   a*b = ((a+b)^2 - |a-b|^2) / 4
// Both squares go through one shift-add squarer that looks at one bit of the
// squared operand per cycle, LSB first. The sum square is added into the
// accumulator, the difference square is subtracted from it, so the product
// falls out of the accumulator with the two low bits dropped.
// Ports:
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : ib_mul_qs_seq_if slave modport (operand in, product out, busy)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | o_ready high, waiting for an operand pair
//   SQS   | WIDTH+1 cycles adding (a+b)^2 into the accumulator
//   SQD   | WIDTH cycles subtracting |a-b|^2 from the accumulator
//   DONE  | o_valid high with o_c loaded, waiting for i_ready
module ib_mul_qs_seq #(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ib_mul_qs_seq_if.slave    bus
);
    localparam int ACC_W = 2*WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, SQS, SQD, DONE} state_t;

    state_t             state_q;
    logic               ready_q;
    logic               valid_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] c_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   mcand_q;
    logic [WIDTH:0]     mplier_q;
    logic [WIDTH-1:0]   d_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     s_sum;
    logic [WIDTH-1:0]   d_abs;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   sum_add;
    logic [ACC_W-1:0]   sum_sub;

    always_comb begin
        s_sum   = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        d_abs   = (bus.i_a >= bus.i_b) ? (bus.i_a - bus.i_b) : (bus.i_b - bus.i_a);
        term    = mplier_q[0] ? mcand_q : '0;
        sum_add = acc_q + term;
        // s^2 >= d^2 and the partial sums of d^2 only grow, so this never wraps
        // below the final value.
        sum_sub = acc_q - term;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            c_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        state_q  <= SQS;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        acc_q    <= '0;
                        mplier_q <= s_sum;
                        mcand_q  <= ACC_W'(s_sum);
                        d_q      <= d_abs;
                        cnt_q    <= CNT_W'(WIDTH);
                    end
                end
                SQS: begin
                    acc_q <= sum_add;
                    if (cnt_q == '0) begin
                        // Reload the shared squarer with |a-b|.
                        state_q  <= SQD;
                        mplier_q <= {1'b0, d_q};
                        mcand_q  <= ACC_W'(d_q);
                        cnt_q    <= CNT_W'(WIDTH - 1);
                    end else begin
                        mplier_q <= mplier_q >> 1;
                        mcand_q  <= mcand_q << 1;
                        cnt_q    <= cnt_q - CNT_W'(1);
                    end
                end
                SQD: begin
                    acc_q    <= sum_sub;
                    mplier_q <= mplier_q >> 1;
                    mcand_q  <= mcand_q << 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        // The difference of squares is always a multiple of 4.
                        state_q <= DONE;
                        c_q     <= sum_sub[ACC_W-1:2];
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_c     = c_q;
endmodule

// File: tb/tb_ib_mul_qs_seq.sv
// Bench for ib_mul_qs_seq: three instances (WIDTH 4, 8, 16) share one set of
// stimulus signals; cur_w picks which instance receives i_valid and whose
// outputs are observed. Expected products come from plain a*b arithmetic.
// Latency is counted with the cycle right after the accepting edge as cycle 1.
module tb_ib_mul_qs_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_t = 1'b0;
    logic        ready_t = 1'b0;
    logic [15:0] a_t = '0;
    logic [15:0] b_t = '0;
    int          cur_w = 8;

    logic        obs_ready;
    logic        obs_valid;
    logic        obs_busy;
    logic [63:0] obs_c;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    ib_mul_qs_seq_if #(.WIDTH(4))  bus4();
    ib_mul_qs_seq_if #(.WIDTH(8))  bus8();
    ib_mul_qs_seq_if #(.WIDTH(16)) bus16();

    assign bus4.i_valid  = valid_t && (cur_w == 4);
    assign bus4.i_a      = a_t[3:0];
    assign bus4.i_b      = b_t[3:0];
    assign bus4.i_ready  = ready_t;
    assign bus8.i_valid  = valid_t && (cur_w == 8);
    assign bus8.i_a      = a_t[7:0];
    assign bus8.i_b      = b_t[7:0];
    assign bus8.i_ready  = ready_t;
    assign bus16.i_valid = valid_t && (cur_w == 16);
    assign bus16.i_a     = a_t;
    assign bus16.i_b     = b_t;
    assign bus16.i_ready = ready_t;

    ib_mul_qs_seq #(.WIDTH(4))  u_dut4  (.i_clk(clk), .i_rst(rst), .bus(bus4));
    ib_mul_qs_seq #(.WIDTH(8))  u_dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));
    ib_mul_qs_seq #(.WIDTH(16)) u_dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16));

    always_comb begin
        case (cur_w)
            4: begin
                obs_ready = bus4.o_ready;
                obs_valid = bus4.o_valid;
                obs_busy  = bus4.o_busy;
                obs_c     = 64'(bus4.o_c);
            end
            16: begin
                obs_ready = bus16.o_ready;
                obs_valid = bus16.o_valid;
                obs_busy  = bus16.o_busy;
                obs_c     = 64'(bus16.o_c);
            end
            default: begin
                obs_ready = bus8.o_ready;
                obs_valid = bus8.o_valid;
                obs_busy  = bus8.o_busy;
                obs_c     = 64'(bus8.o_c);
            end
        endcase
    end

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, width %0d)", tag, got, exp, $time, cur_w);
        end
    endtask

    function automatic logic [63:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        logic [63:0] m;
        m = (64'd1 << cur_w) - 64'd1;
        return (64'(a) & m) * (64'(b) & m);
    endfunction

    // Called at a negedge with the selected instance idle; returns at a negedge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          output logic [63:0] got);
        logic [63:0] exp;
        int lat;
        exp = model_mul(a, b);
        a_t = a;
        b_t = b;
        valid_t = 1'b1;
        ready_t = (hold == 0);
        check_eq("ready_before_accept", 64'(obs_ready), 1);
        @(posedge clk);
        #1;
        valid_t = 1'b0;
        a_t = 16'($urandom);
        b_t = 16'($urandom);
        check_eq("ready_low_when_busy", 64'(obs_ready), 0);
        check_eq("busy_after_accept", 64'(obs_busy), 1);
        lat = 1;
        while (!obs_valid && lat < 200) begin
            @(posedge clk);
            #1;
            a_t = 16'($urandom);
            b_t = 16'($urandom);
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(2*cur_w + 2));
        check_eq("product", obs_c, exp);
        got = obs_c;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(obs_valid), 1);
            check_eq("hold_product", obs_c, exp);
            check_eq("hold_ready_low", 64'(obs_ready), 0);
        end
        ready_t = 1'b1;
        @(posedge clk);
        #1;
        ready_t = 1'b0;
        check_eq("valid_clears", 64'(obs_valid), 0);
        check_eq("ready_after_out", 64'(obs_ready), 1);
        check_eq("product_retained", obs_c, exp);
        @(negedge clk);
    endtask

    // One random cycle with scoreboard tracking of both handshakes.
    task automatic rnd_cycle(input logic v, input logic r);
        logic [63:0] e;
        valid_t = v;
        ready_t = r;
        a_t = 16'($urandom);
        b_t = 16'($urandom);
        #1;
        if (valid_t && obs_ready)
            exp_q.push_back(model_mul(a_t, b_t));
        if (obs_valid && ready_t) begin
            check_eq("rnd_result_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("rnd_product", obs_c, e);
            end
        end
        @(negedge clk);
    endtask

    logic [15:0] dir_a[5] = '{16'd0, 16'd173, 16'd1, 16'd13, 16'd200};
    logic [15:0] dir_b[5] = '{16'd173, 16'd0, 16'd1, 16'd13, 16'd3};
    logic [63:0] dir_c[5] = '{64'd0, 64'd0, 64'd1, 64'd169, 64'd600};

    initial begin
        logic [63:0] got;
        int saw;
        int hs_cyc[$];
        int cyc;

        #1 rst = 1'b1;
        #12;
        check_eq("rst_ready", 64'(obs_ready), 1);
        check_eq("rst_valid", 64'(obs_valid), 0);
        check_eq("rst_busy", 64'(obs_busy), 0);
        check_eq("rst_c", obs_c, 0);
        @(negedge clk);
        rst = 1'b0;

        // first edge after reset release must accept
        run_op(16'd255, 16'd255, 0, got);
        check_eq("max8", got, 64'd65025);

        for (int i = 0; i < 5; i++) begin
            run_op(dir_a[i], dir_b[i], 0, got);
            check_eq("directed8", got, dir_c[i]);
        end

        run_op(16'd7, 16'd9, 5, got);
        check_eq("stall_7x9", got, 64'd63);

        // reset in the middle of the difference-square phase
        a_t = 16'd37;
        b_t = 16'd91;
        valid_t = 1'b1;
        @(posedge clk);
        #1 valid_t = 1'b0;
        repeat (cur_w + 4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(obs_valid), 0);
        check_eq("midrst_busy", 64'(obs_busy), 0);
        check_eq("midrst_c", obs_c, 0);
        check_eq("midrst_ready", 64'(obs_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (3*cur_w) begin
            @(posedge clk);
            #1;
            if (obs_valid) saw++;
        end
        check_eq("no_valid_after_rst", 64'(saw), 0);
        @(negedge clk);
        run_op(16'd100, 16'd50, 0, got);
        check_eq("after_rst_100x50", got, 64'd5000);

        // back-to-back issue interval with valid and ready held high
        valid_t = 1'b1;
        ready_t = 1'b1;
        a_t = 16'd3;
        b_t = 16'd5;
        cyc = 0;
        while (hs_cyc.size() < 3 && cyc < 200) begin
            if (valid_t && obs_ready) hs_cyc.push_back(cyc);
            @(negedge clk);
            cyc++;
        end
        valid_t = 1'b0;
        check_eq("b2b_count", 64'(hs_cyc.size()), 3);
        if (hs_cyc.size() == 3) begin
            check_eq("b2b_interval1", 64'(hs_cyc[1] - hs_cyc[0]), 64'(2*cur_w + 3));
            check_eq("b2b_interval2", 64'(hs_cyc[2] - hs_cyc[1]), 64'(2*cur_w + 3));
        end
        saw = 0;
        while (obs_busy && saw < 100) begin
            @(negedge clk);
            saw++;
        end
        ready_t = 1'b0;
        @(negedge clk);

        cur_w = 4;
        #1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(16'(a), 16'(b), 0, got);

        cur_w = 16;
        #1;
        run_op(16'hFFFF, 16'hFFFF, 0, got);
        check_eq("max16", got, 64'd4294836225);
        run_op(16'd40000, 16'd3, 2, got);

        cur_w = 8;
        #1;
        for (int i = 0; i < 3000; i++)
            rnd_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 100; i++)
            rnd_cycle(1'b0, 1'b1);
        check_eq("rnd_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 2000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ib_mul_qs_seq.md
IB_MUL_QS_SEQ -- requirements
Module: ib_mul_qs_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port i_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  operand pair valid.
REQ-005 SHALL have port o_ready  output  1  block accepts operands.
REQ-006 SHALL have port i_a  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port i_b  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port o_valid  output  1  product valid.
REQ-009 SHALL have port i_ready  input  1  downstream accepts product.
REQ-010 SHALL have port o_c  output  2*WIDTH  unsigned product.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL compute o_c = i_a * i_b by quarter-squares: s = i_a + i_b (WIDTH+1 bits), d = |i_a - i_b| (WIDTH bits), o_c = (s*s - d*d) >> 2, with intermediates of at least 2*WIDTH+2 bits and no truncation before the final shift.
REQ-013 SHALL use one shared shift-add squarer, examining one squared-operand bit per cycle, LSB first; no `*` operator.
REQ-014 SHALL implement states IDLE, SQS, SQD and DONE.
REQ-015 SHALL drive o_ready=1 only in IDLE; input handshake = i_valid && o_ready on a rising edge.
REQ-016 On input handshake, SHALL register s and d and enter SQS; otherwise IDLE SHALL hold.
REQ-017 SHALL remain in SQS for exactly WIDTH+1 cycles, accumulating s*s, then enter SQD.
REQ-018 SHALL remain in SQD for exactly WIDTH cycles, accumulating d*d, then enter DONE with o_c loaded.
REQ-019 Latency SHALL be fixed: o_valid rises 2*WIDTH+2 cycles after the input-handshake edge, regardless of operand values (no early exit).
REQ-020 In DONE, SHALL drive o_valid=1; on i_ready=1, the next state SHALL be IDLE and o_valid SHALL clear on that edge.
REQ-021 While o_valid=1 and i_ready=0, o_c SHALL be held stable.
REQ-022 i_a and i_b SHALL be ignored outside the input-handshake cycle; input changes mid-operation SHALL NOT affect the result.
REQ-023 Back-to-back: o_ready SHALL assert the cycle after the output handshake; minimum issue interval = 2*WIDTH+3 cycles.
REQ-024 When i_a == i_b, d = 0 and the SQD phase SHALL still take WIDTH cycles.
REQ-025 o_c SHALL retain the last product after the output handshake until the next DONE load.

Reset
REQ-026 On i_rst=1, SHALL immediately and asynchronously enter IDLE with o_valid=0, o_busy=0, o_c=0 and accumulators cleared; o_ready=1 once in IDLE.
REQ-027 Assertion of i_rst mid-operation (SQS/SQD/DONE) SHALL discard the operation; no o_valid SHALL follow.
REQ-028 First handshake SHALL be accepted on the first rising edge after i_rst deasserts.

Verification
REQ-029 WIDTH=8, i_a=255, i_b=255, i_ready=1 -> o_valid exactly 18 cycles after accept, o_c=65025.
REQ-030 WIDTH=8, (0,173), (173,0), (1,1), (13,13), (200,3) -> o_c = 0, 0, 1, 169, 600, each at latency 18.
REQ-031 WIDTH=8, 7*9 with i_ready=0 held for 5 cycles after o_valid -> o_c=63 stable, o_ready=0 throughout; o_ready=1 one cycle after i_ready=1.
REQ-032 WIDTH=8, i_rst pulsed during SQD -> o_valid never rises, o_ready=1 after reset; next op 100*50 -> o_c=5000.
REQ-033 WIDTH=4, exhaustive 16x16 -> o_c = i_a*i_b, latency 10; WIDTH=16, 65535*65535 -> o_c=4294836225, latency 34.
REQ-034 Random operands with random i_valid/i_ready and i_a/i_b toggled mid-operation -> every product matches the captured operands, with no lost or duplicated results.
